// File: rtl/radix_to_binary.sv
// rtl/radix_to_binary.sv - radix-MODULUS digit stream to binary word assembler (optional RADIX_DIGIT_CHECK_EN)
module radix_to_binary #(
  parameter int DATA_WIDTH = 8,
  parameter int MODULUS    = 7,
  parameter int NUM_DIGITS = 2,
  localparam int DW        = $clog2(MODULUS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DW-1:0]         digit_i,
  input  logic                  digit_valid_i,
  output logic                  digit_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  overflow_o,
  output logic                  digit_err_o
);

  localparam int WW = DATA_WIDTH + DW + 1;
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_DIGITS - 1);
  localparam bit POW2 = ((MODULUS & (MODULUS - 1)) == 0);

  typedef enum logic {
    ST_ACCUM,
    ST_OUTPUT
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [CW-1:0]         cnt;
  logic                  ovf;
  logic [WW-1:0]         step_sum;
  logic                  step_ovf;
  logic                  digit_fire;
  logic                  word_fire;

  assign digit_fire = digit_valid_i & digit_ready_o;
  assign word_fire  = data_valid_o & data_ready_i;

  generate
    if (POW2) begin : g_shift
      // Radix is a power of two: the step is a plain shift-in of the digit
      always_comb step_sum = {1'b0, acc, digit_i};
    end else begin : g_mul
      localparam logic [WW-1:0] MOD_K = WW'(MODULUS);
      // Multiply-by-constant step, wide enough that the true result never wraps
      always_comb step_sum = {{(DW + 1){1'b0}}, acc} * MOD_K
                             + {{(DATA_WIDTH + 1){1'b0}}, digit_i};
    end
  endgenerate

  assign step_ovf = |step_sum[WW-1:DATA_WIDTH];

  // Control FSM: accumulate NUM_DIGITS digits, then present the word until taken
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_ACCUM;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      digit_ready_o <= 1'b1;
      data_valid_o  <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (digit_fire) begin
            acc <= step_sum[DATA_WIDTH-1:0];
            ovf <= ovf | step_ovf;
            if (cnt == LAST_CNT) begin
              cnt           <= '0;
              state         <= ST_OUTPUT;
              digit_ready_o <= 1'b0;
              data_valid_o  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_OUTPUT: begin
          if (word_fire) begin
            acc           <= '0;
            ovf           <= 1'b0;
            state         <= ST_ACCUM;
            digit_ready_o <= 1'b1;
            data_valid_o  <= 1'b0;
          end
        end
        default: begin
          state         <= ST_ACCUM;
          digit_ready_o <= 1'b1;
          data_valid_o  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o     = acc;
  assign overflow_o = ovf;

`ifdef RADIX_DIGIT_CHECK_EN
  localparam int DW1 = DW + 1;
  localparam logic [DW:0] MOD_D = DW1'(MODULUS);
  logic err;

  // Sticky illegal-digit flag for the word in flight, cleared when the word is taken
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (word_fire) begin
      err <= 1'b0;
    end else if (digit_fire && ({1'b0, digit_i} >= MOD_D)) begin
      err <= 1'b1;
    end
  end

  assign digit_err_o = err;
`else
  assign digit_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_radix_to_binary.sv
// tb/tb_radix_to_binary.sv - self-checking bench for radix_to_binary
module tb_radix_to_binary;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] digit       [NI];
  logic       digit_valid [NI];
  logic       digit_ready [NI];
  logic [7:0] data        [NI];
  logic       data_valid  [NI];
  logic       data_ready  [NI];
  logic       overflow    [NI];
  logic       digit_err   [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  radix_to_binary #(.DATA_WIDTH(8), .MODULUS(7), .NUM_DIGITS(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .digit_i(digit[0]), .digit_valid_i(digit_valid[0]),
    .digit_ready_o(digit_ready[0]), .data_o(data[0]), .data_valid_o(data_valid[0]),
    .data_ready_i(data_ready[0]), .overflow_o(overflow[0]), .digit_err_o(digit_err[0]));

  radix_to_binary #(.DATA_WIDTH(8), .MODULUS(7), .NUM_DIGITS(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .digit_i(digit[1]), .digit_valid_i(digit_valid[1]),
    .digit_ready_o(digit_ready[1]), .data_o(data[1]), .data_valid_o(data_valid[1]),
    .data_ready_i(data_ready[1]), .overflow_o(overflow[1]), .digit_err_o(digit_err[1]));

  radix_to_binary #(.DATA_WIDTH(8), .MODULUS(8), .NUM_DIGITS(3)) dut2 (
    .clk_i(clk), .rst_i(rst), .digit_i(digit[2]), .digit_valid_i(digit_valid[2]),
    .digit_ready_o(digit_ready[2]), .data_o(data[2]), .data_valid_o(data_valid[2]),
    .data_ready_i(data_ready[2]), .overflow_o(overflow[2]), .digit_err_o(digit_err[2]));

  function automatic int mod_of(input int i);
    return (i == 2) ? 8 : 7;
  endfunction

  function automatic int nd_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  // Reference: plain integer value = value*M + d, reduced mod 256 after each step
  function automatic void model(input int i, input int d0, input int d1, input int d2,
                                output int v, output bit ovf, output bit err);
    int dd[3];
    dd = '{d0, d1, d2};
    v = 0; ovf = 1'b0; err = 1'b0;
    for (int k = 0; k < nd_of(i); k++) begin
      v = v * mod_of(i) + dd[k];
      if (v > 255) ovf = 1'b1;
      v = v % 256;
      if (dd[k] >= mod_of(i)) err = 1'b1;
    end
`ifndef RADIX_DIGIT_CHECK_EN
    err = 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input int i, input int d0, input int d1, input int d2,
                          input int gap, input int hold, input string name);
    int dd[3];
    int ev;
    bit eo;
    bit ee;
    dd = '{d0, d1, d2};
    model(i, d0, d1, d2, ev, eo, ee);
    for (int k = 0; k < nd_of(i); k++) begin
      for (int g = 0; g < gap; g++) begin
        digit_valid[i] = 1'b0;
        step();
        checks++;
        if (digit_ready[i] !== 1'b1 || data_valid[i] !== 1'b0) begin
          errors++;
          $display("FAIL %s gap_state ready=%b valid=%b required ready=1 valid=0",
                   name, digit_ready[i], data_valid[i]);
        end
      end
      digit[i] = 3'(dd[k]);
      digit_valid[i] = 1'b1;
      checks++;
      if (digit_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL %s digit_ready got=%b required=1", name, digit_ready[i]);
      end
      step();
      digit_valid[i] = 1'b0;
      checks++;
      if (data_valid[i] !== ((k == nd_of(i) - 1) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL %s data_valid_latency digit=%0d got=%b", name, k, data_valid[i]);
      end
    end
    checks++;
    if (data[i] !== 8'(ev) || overflow[i] !== eo || digit_err[i] !== ee) begin
      errors++;
      $display("FAIL %s word got data=%0d ovf=%b err=%b required data=%0d ovf=%b err=%b",
               name, data[i], overflow[i], digit_err[i], ev, eo, ee);
    end
    for (int h = 0; h < hold; h++) begin
      data_ready[i]  = 1'b0;
      digit_valid[i] = 1'b1;
      digit[i]       = 3'($urandom_range(0, 7));
      step();
      checks++;
      if (data[i] !== 8'(ev) || data_valid[i] !== 1'b1 || digit_ready[i] !== 1'b0
          || overflow[i] !== eo) begin
        errors++;
        $display("FAIL %s hold got data=%0d valid=%b ready=%b required data=%0d valid=1 ready=0",
                 name, data[i], data_valid[i], digit_ready[i], ev);
      end
    end
    digit_valid[i] = 1'b0;
    data_ready[i]  = 1'b1;
    step();
    data_ready[i]  = 1'b0;
    checks++;
    if (data_valid[i] !== 1'b0 || digit_ready[i] !== 1'b1 || overflow[i] !== 1'b0
        || digit_err[i] !== 1'b0) begin
      errors++;
      $display("FAIL %s release got valid=%b ready=%b ovf=%b err=%b required 0 1 0 0",
               name, data_valid[i], digit_ready[i], overflow[i], digit_err[i]);
    end
  endtask

  task automatic check_reset_vals(input string name);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (digit_ready[i] !== 1'b1 || data_valid[i] !== 1'b0 || data[i] !== 8'd0
          || overflow[i] !== 1'b0 || digit_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s inst=%0d got ready=%b valid=%b data=%0d ovf=%b err=%b required 1 0 0 0 0",
                 name, i, digit_ready[i], data_valid[i], data[i], overflow[i], digit_err[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    run_word(0, 3, 5, 0, 0, 0, "basic_26");
    run_word(2, 7, 7, 7, 0, 1, "pow2_overflow");
    run_word(2, 1, 2, 3, 1, 0, "pow2_83");
  endtask

  task automatic test_back_to_back();
    int q[4];
    int idx;
    int lows;
    int got[$];
    q = '{6, 6, 0, 1};
    idx = 0;
    lows = 0;
    data_ready[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (data_valid[0] === 1'b1) got.push_back(int'(data[0]));
      if (digit_ready[0] !== 1'b1) lows++;
      if (digit_ready[0] === 1'b1 && idx < 4) begin
        digit[0] = 3'(q[idx]);
        digit_valid[0] = 1'b1;
        idx++;
      end else begin
        digit_valid[0] = 1'b0;
      end
      step();
    end
    data_ready[0] = 1'b0;
    digit_valid[0] = 1'b0;
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got=%0d required=2", got.size());
    end else begin
      checks++;
      if (got[0] != 48 || got[1] != 1) begin
        errors++;
        $display("FAIL b2b_words got=%0d,%0d required=48,1", got[0], got[1]);
      end
    end
    checks++;
    if (lows != 2) begin
      errors++;
      $display("FAIL b2b_ready_low got=%0d required=2", lows);
    end
  endtask

  task automatic test_overflow();
    run_word(1, 6, 6, 6, 0, 1, "overflow_342");
    run_word(1, 0, 0, 1, 0, 0, "after_overflow");
  endtask

  task automatic test_backpressure();
    run_word(0, 2, 4, 0, 3, 5, "backpressure_18");
  endtask

  task automatic test_reset_mid();
    digit[0] = 3'd5;
    digit_valid[0] = 1'b1;
    step();
    digit_valid[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_vals("reset_mid_word");
    @(negedge clk);
    rst = 1'b0;
    step();
    run_word(0, 1, 2, 0, 0, 0, "after_reset_9");
    for (int k = 0; k < 2; k++) begin
      digit[0] = 3'd6;
      digit_valid[0] = 1'b1;
      step();
    end
    digit_valid[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_vals("reset_mid_output");
    @(negedge clk);
    rst = 1'b0;
    step();
    run_word(0, 4, 1, 0, 0, 0, "after_reset_29");
  endtask

  task automatic test_digit_check();
    run_word(0, 7, 0, 0, 0, 0, "digit_check_49");
    run_word(0, 1, 1, 0, 0, 0, "digit_check_clear");
  endtask

  task automatic test_random();
    for (int i = 0; i < NI; i++) begin
      for (int w = 0; w < 25; w++) begin
        run_word(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), "random");
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      digit[i]       = 3'd0;
      digit_valid[i] = 1'b0;
      data_ready[i]  = 1'b0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_digit_check();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/radix_to_binary.md
# radix_to_binary

Sequential radix-MODULUS to binary assembler: accepts a stream of base-MODULUS digits, most significant first, and rebuilds the binary word `acc = acc*MODULUS + digit`. It is the inverse of a chain of modulo reducers: the residues that such a chain extracts from a word are fed back here and reassembled. It sits on the receive side of residue-coded links, with valid/ready handshakes on both the digit and word sides.

## Interface
- DATA_WIDTH, 8, width of the reconstructed word; 2..63.
- MODULUS, 7, digit radix; 2 <= MODULUS < 2^DATA_WIDTH.
- NUM_DIGITS, 2, digits per word; >= 1.
- DW = $clog2(MODULUS), digit width (localparam).

- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- digit_i  in  DW  input digit, MSD first.
- digit_valid_i  in  1  digit_i is valid.
- digit_ready_o  out  1  block accepts a digit this cycle.
- data_o  out  DATA_WIDTH  reconstructed word; low DATA_WIDTH bits on overflow.
- data_valid_o  out  1  data_o, overflow_o and digit_err_o are valid.
- data_ready_i  in  1  downstream accepts the word.
- overflow_o  out  1  the word exceeded 2^DATA_WIDTH-1 at any step.
- digit_err_o  out  1  the word had a digit >= MODULUS (see Configuration).

## Operation
- States: ACCUM and OUTPUT. Reset enters ACCUM with acc=0, cnt=0, ovf=0, err=0.
- ACCUM:
  - digit_ready_o=1, data_valid_o=0.
  - On digit_valid_i && digit_ready_o: acc <= acc*MODULUS + digit_i, cnt++, ovf |= step overflow.
  - On the handshake with cnt==NUM_DIGITS-1: go to OUTPUT.
- OUTPUT:
  - digit_ready_o=0, data_valid_o=1.
  - data_o, overflow_o and digit_err_o are held stable.
  - On data_ready_i: go to ACCUM and clear acc, cnt, ovf and err in the same edge.
- Arithmetic:
  - The product and sum are formed at DATA_WIDTH+DW+1 bits.
  - Step overflow is set if the result > 2^DATA_WIDTH-1.
  - The stored acc is truncated to DATA_WIDTH bits.
  - ovf is sticky for the whole word.
- Power-of-two MODULUS: implemented as acc <= {acc, digit_i} truncated; no multiplier. Overflow is any nonzero bit shifted out.
- Non-power-of-two MODULUS: the multiply-by-constant is resolved at elaboration.
- No digit is lost or accepted twice.
- digit_ready_o does not depend combinationally on digit_valid_i.
- data_valid_o does not depend combinationally on data_ready_i.
- NUM_DIGITS=1: every accepted digit produces a word.

## Timing
- Reset values: digit_ready_o=1, data_valid_o=0, data_o=0, overflow_o=0, digit_err_o=0.
- Latency: data_valid_o rises on the cycle after the final digit handshake.
- Throughput: NUM_DIGITS+1 cycles per word at best. Digit acceptance restarts the cycle after the word handshake; there is no overlap.
- Backpressure: OUTPUT is held indefinitely while data_ready_i=0.
- digit_valid_i may toggle between digits; gaps are tolerated and the partial acc is retained.
- Reset mid-word or mid-OUTPUT: the partial word is discarded and the block immediately returns to its reset values.

## Configuration
- RADIX_DIGIT_CHECK_EN:
  - Defined: any accepted digit_i >= MODULUS sets the sticky err for the current word. digit_err_o is presented with the word and cleared on the word handshake. The illegal digit is still accumulated as given.
  - Undefined: the check logic is absent and digit_err_o is tied to 0.

## Test plan
- Basic assembly (MODULUS=7, NUM_DIGITS=2, DATA_WIDTH=8): digits 3,5 -> data_o=26, overflow_o=0; data_valid_o one cycle after the 2nd digit.
- Max value and back-to-back words: digits 6,6 then 0,1 with data_ready_i=1 -> 48 then 1. digit_ready_o is low for exactly one cycle per word.
- Overflow (MODULUS=7, NUM_DIGITS=3, DATA_WIDTH=8): digits 6,6,6 -> 342 -> overflow_o=1, data_o=86. The next word 0,0,1 -> overflow_o=0, data_o=1.
- Backpressure and gaps: insert 3 idle cycles between digits 2,4, then hold data_ready_i=0 for 5 cycles. Required: data_o=18 held stable, digit_ready_o=0 throughout, and no digit is accepted.
- Reset mid-word: accept digit 5, assert rst_i asynchronously. Required: outputs go to reset values; the next digits 1,2 -> data_o=9.
- Digit check (MODULUS=7, NUM_DIGITS=2, macro defined): digits 7,0 -> digit_err_o=1, data_o=49. With the macro undefined: digit_err_o=0 and data_o=49.
